// File: rtl/store_queue_if.sv
// +--------------------------------------------------------------------+
// | store_queue_if : dispatch/resolve/commit/load/D-cache signal group |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface store_queue_if #(
  parameter int XLEN     = 32,
  parameter int SQ_LEN   = 3,
  parameter int PREG_LEN = 5
);
  logic                sq_enable;
  logic                squash;
  logic                rs_sq_out_valid;
  logic [SQ_LEN-1:0]   rs_sq_idx;
  logic [XLEN-1:0]     rs_sq_addr;
  logic [XLEN-1:0]     rs_sq_data;
  logic [1:0]          rs_sq_size;
  logic                rob_commit_store;
  logic                lb_request_valid;
  logic [XLEN-1:0]     lb_request_addr;
  logic [SQ_LEN-1:0]   lb_request_age;
  logic [1:0]          lb_request_size;
  logic [PREG_LEN-1:0] lb_request_preg;
  logic                dcache_sq_ack;
  logic                sq_full;
  logic                sq_empty;
  logic [SQ_LEN-1:0]   sq_head;
  logic [SQ_LEN-1:0]   sq_tail;
  logic                sq_addr_all_rsvd;
  logic [SQ_LEN-1:0]   secure_age;
  logic                sq_fwd_valid;
  logic                sq_fwd_hit;
  logic                sq_fwd_retry;
  logic [XLEN-1:0]     sq_fwd_data;
  logic [PREG_LEN-1:0] sq_fwd_preg;
  logic                sq_dcache_valid;
  logic [XLEN-1:0]     sq_dcache_addr;
  logic [XLEN-1:0]     sq_dcache_data;
  logic [1:0]          sq_dcache_size;

  modport master (
    output sq_enable, squash, rs_sq_out_valid, rs_sq_idx, rs_sq_addr, rs_sq_data, rs_sq_size,
           rob_commit_store, lb_request_valid, lb_request_addr, lb_request_age, lb_request_size,
           lb_request_preg, dcache_sq_ack,
    input  sq_full, sq_empty, sq_head, sq_tail, sq_addr_all_rsvd, secure_age, sq_fwd_valid,
           sq_fwd_hit, sq_fwd_retry, sq_fwd_data, sq_fwd_preg, sq_dcache_valid, sq_dcache_addr,
           sq_dcache_data, sq_dcache_size
  );

  modport slave (
    input  sq_enable, squash, rs_sq_out_valid, rs_sq_idx, rs_sq_addr, rs_sq_data, rs_sq_size,
           rob_commit_store, lb_request_valid, lb_request_addr, lb_request_age, lb_request_size,
           lb_request_preg, dcache_sq_ack,
    output sq_full, sq_empty, sq_head, sq_tail, sq_addr_all_rsvd, secure_age, sq_fwd_valid,
           sq_fwd_hit, sq_fwd_retry, sq_fwd_data, sq_fwd_preg, sq_dcache_valid, sq_dcache_addr,
           sq_dcache_data, sq_dcache_size
  );
endinterface

`default_nettype wire

// File: rtl/store_queue.sv
// +--------------------------------------------------------------------+
// | store_queue : circular store queue with load forwarding and drain  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module store_queue #(
  parameter int XLEN        = 32,
  parameter int SQ_CAPACITY = 8,
  parameter int SQ_LEN      = 3,
  parameter int PREG_LEN    = 5
) (
  input  wire logic     clock,
  input  wire logic     reset,
  store_queue_if.slave  sq
);
  logic [SQ_LEN-1:0]   r_head, r_tail, r_cptr;
  logic [SQ_LEN:0]     r_count, r_ccount;
  logic [SQ_CAPACITY-1:0] r_valid, r_rsvd;
  logic [XLEN-1:0]     r_addr [SQ_CAPACITY];
  logic [XLEN-1:0]     r_data [SQ_CAPACITY];
  logic [1:0]          r_size [SQ_CAPACITY];
  logic                r_fwd_valid, r_fwd_hit, r_fwd_retry;
  logic [XLEN-1:0]     r_fwd_data;
  logic [PREG_LEN-1:0] r_fwd_preg;

  logic                w_full, w_empty, w_dc_valid, w_pop, w_commit, w_alloc;
  logic [SQ_LEN-1:0]   w_head_nxt, w_cptr_nxt;
  logic [SQ_LEN:0]     w_ccount_nxt;
  logic [SQ_CAPACITY-1:0] w_keep;
  logic [SQ_LEN-1:0]   w_keep_off;

  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    byte_mask = 4'b0001 << off;
      2'd1:    byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = XLEN'(32'h0000_00FF);
      2'd1:    size_mask = XLEN'(32'h0000_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  assign w_full       = (r_count == (SQ_LEN+1)'(SQ_CAPACITY));
  assign w_empty      = (r_count == '0);
  assign w_dc_valid   = (r_ccount != '0) && r_rsvd[r_head];
  assign w_pop        = w_dc_valid && sq.dcache_sq_ack;
  assign w_commit     = sq.rob_commit_store;
  assign w_alloc      = sq.sq_enable && !w_full && !sq.squash;
  assign w_head_nxt   = r_head + SQ_LEN'(w_pop);
  assign w_cptr_nxt   = r_cptr + SQ_LEN'(w_commit);
  assign w_ccount_nxt = r_ccount + (SQ_LEN+1)'(w_commit) - (SQ_LEN+1)'(w_pop);

  // Entries surviving a squash: the committed region after this cycle's commit/pop.
  always_comb begin
    w_keep     = '0;
    w_keep_off = '0;
    for (int i = 0; i < SQ_CAPACITY; i++) begin
      w_keep_off = SQ_LEN'(i) - w_head_nxt;
      w_keep[i]  = ((SQ_LEN+1)'(w_keep_off) < w_ccount_nxt);
    end
  end

  logic              w_found;
  logic [SQ_LEN-1:0] w_secure, w_scan_idx;

  always_comb begin
    w_found    = 1'b0;
    w_secure   = r_tail;
    w_scan_idx = '0;
    for (int k = 0; k < SQ_CAPACITY; k++) begin
      w_scan_idx = r_head + SQ_LEN'(k);
      if (!w_found && ((SQ_LEN+1)'(k) < r_count) && !r_rsvd[w_scan_idx]) begin
        w_found  = 1'b1;
        w_secure = w_scan_idx;
      end
    end
  end

  logic              w_lk_hit, w_lk_retry;
  logic [XLEN-1:0]   w_lk_data;
  logic [SQ_LEN-1:0] w_nolder, w_lk_idx;
  logic [3:0]        w_lmask, w_smask;

  // Ascending scan from head, so the youngest older overlapping store wins.
  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_retry = 1'b0;
    w_lk_data  = '0;
    w_lk_idx   = '0;
    w_smask    = '0;
    w_lmask    = byte_mask(sq.lb_request_size, sq.lb_request_addr[1:0]);
    w_nolder   = sq.lb_request_age - r_head;
    for (int k = 0; k < SQ_CAPACITY; k++) begin
      w_lk_idx = r_head + SQ_LEN'(k);
      w_smask  = byte_mask(r_size[w_lk_idx], r_addr[w_lk_idx][1:0]);
      if ((SQ_LEN'(k) < w_nolder) && r_valid[w_lk_idx] && r_rsvd[w_lk_idx] &&
          (r_addr[w_lk_idx][XLEN-1:2] == sq.lb_request_addr[XLEN-1:2]) &&
          ((w_smask & w_lmask) != 4'b0000)) begin
        if ((w_smask & w_lmask) == w_lmask) begin
          w_lk_hit   = 1'b1;
          w_lk_retry = 1'b0;
          w_lk_data  = ((r_data[w_lk_idx] << (8 * r_addr[w_lk_idx][1:0]))
                        >> (8 * sq.lb_request_addr[1:0])) & size_mask(sq.lb_request_size);
        end else begin
          w_lk_hit   = 1'b0;
          w_lk_retry = 1'b1;
          w_lk_data  = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_cptr      <= '0;
      r_count     <= '0;
      r_ccount    <= '0;
      r_valid     <= '0;
      r_rsvd      <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_hit   <= 1'b0;
      r_fwd_retry <= 1'b0;
      r_fwd_data  <= '0;
      r_fwd_preg  <= '0;
    end else begin
      r_head   <= w_head_nxt;
      r_cptr   <= w_cptr_nxt;
      r_ccount <= w_ccount_nxt;
      if (sq.squash) begin
        r_tail  <= w_cptr_nxt;
        r_count <= w_ccount_nxt;
      end else begin
        r_tail  <= r_tail + SQ_LEN'(w_alloc);
        r_count <= r_count + (SQ_LEN+1)'(w_alloc) - (SQ_LEN+1)'(w_pop);
      end
      if (sq.rs_sq_out_valid && r_valid[sq.rs_sq_idx]) begin
        r_rsvd[sq.rs_sq_idx] <= 1'b1;
        r_addr[sq.rs_sq_idx] <= sq.rs_sq_addr;
        r_data[sq.rs_sq_idx] <= sq.rs_sq_data;
        r_size[sq.rs_sq_idx] <= sq.rs_sq_size;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_rsvd[r_tail]  <= 1'b0;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_rsvd[r_head]  <= 1'b0;
      end
      if (sq.squash) begin
        for (int i = 0; i < SQ_CAPACITY; i++) begin
          if (!w_keep[i]) begin
            r_valid[i] <= 1'b0;
            r_rsvd[i]  <= 1'b0;
          end
        end
      end
      r_fwd_valid <= sq.lb_request_valid;
      r_fwd_hit   <= sq.lb_request_valid && w_lk_hit;
      r_fwd_retry <= sq.lb_request_valid && w_lk_retry;
      r_fwd_data  <= sq.lb_request_valid ? w_lk_data : '0;
      r_fwd_preg  <= sq.lb_request_valid ? sq.lb_request_preg : '0;
    end
  end

  a_commit_has_store: assert property (@(posedge clock) disable iff (reset)
    sq.rob_commit_store |-> (r_ccount != r_count));

  assign sq.sq_full          = w_full;
  assign sq.sq_empty         = w_empty;
  assign sq.sq_head          = r_head;
  assign sq.sq_tail          = r_tail;
  assign sq.sq_addr_all_rsvd = !w_found;
  assign sq.secure_age       = w_secure;
  assign sq.sq_fwd_valid     = r_fwd_valid;
  assign sq.sq_fwd_hit       = r_fwd_hit;
  assign sq.sq_fwd_retry     = r_fwd_retry;
  assign sq.sq_fwd_data      = r_fwd_data;
  assign sq.sq_fwd_preg      = r_fwd_preg;
  assign sq.sq_dcache_valid  = w_dc_valid;
  assign sq.sq_dcache_addr   = r_addr[r_head];
  assign sq.sq_dcache_data   = r_data[r_head];
  assign sq.sq_dcache_size   = r_size[r_head];
endmodule

`default_nettype wire

// File: tb/tb_store_queue.sv
// +--------------------------------------------------------------------+
// | tb_store_queue : directed stimulus with scoreboarded responses     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_store_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  store_queue_if #(.XLEN(32), .SQ_LEN(3), .PREG_LEN(5)) sq ();

  store_queue #(.XLEN(32), .SQ_CAPACITY(8), .SQ_LEN(3), .PREG_LEN(5)) dut (
    .clock (clock),
    .reset (reset),
    .sq    (sq)
  );

  typedef struct packed { logic hit; logic retry; logic [31:0] data; logic [4:0] preg; } fwd_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [1:0] size; } dc_t;
  fwd_t fwd_q[$];
  dc_t  dc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load-response monitor
  always @(negedge clock) begin
    if (!reset && sq.sq_fwd_valid) begin
      if (fwd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fwd_unexpected: got a response, expected none");
      end else begin
        check("fwd_hit",   32'(sq.sq_fwd_hit),   32'(fwd_q[0].hit));
        check("fwd_retry", 32'(sq.sq_fwd_retry), 32'(fwd_q[0].retry));
        check("fwd_data",  sq.sq_fwd_data,       fwd_q[0].data);
        check("fwd_preg",  32'(sq.sq_fwd_preg),  32'(fwd_q[0].preg));
        void'(fwd_q.pop_front());
      end
    end
  end

  // D-cache write monitor: fields must match (and stay held) until acked
  always @(negedge clock) begin
    if (!reset && sq.sq_dcache_valid) begin
      if (dc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dcache_unexpected: got addr 0x%0h, expected no request", sq.sq_dcache_addr);
      end else begin
        check("dc_addr", sq.sq_dcache_addr,       dc_q[0].addr);
        check("dc_data", sq.sq_dcache_data,       dc_q[0].data);
        check("dc_size", 32'(sq.sq_dcache_size),  32'(dc_q[0].size));
        if (sq.dcache_sq_ack) void'(dc_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic alloc(input int n);
    sq.sq_enable = 1'b1;
    step(n);
    sq.sq_enable = 1'b0;
  endtask

  task automatic set_resolve(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz);
    sq.rs_sq_out_valid = 1'b1;
    sq.rs_sq_idx  = idx;
    sq.rs_sq_addr = a;
    sq.rs_sq_data = d;
    sq.rs_sq_size = sz;
  endtask

  task automatic resolve(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz);
    set_resolve(idx, a, d, sz);
    step();
    sq.rs_sq_out_valid = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] age, input logic [1:0] sz,
                          input logic [4:0] preg, input logic h, input logic r, input logic [31:0] d);
    sq.lb_request_valid = 1'b1;
    sq.lb_request_addr  = a;
    sq.lb_request_age   = age;
    sq.lb_request_size  = sz;
    sq.lb_request_preg  = preg;
    fwd_q.push_back('{hit: h, retry: r, data: d, preg: preg});
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] age, input logic [1:0] sz,
                      input logic [4:0] preg, input logic h, input logic r, input logic [31:0] d);
    set_load(a, age, sz, preg, h, r, d);
    step();
    sq.lb_request_valid = 1'b0;
  endtask

  task automatic ack_after(input int delay);
    step(delay);
    sq.dcache_sq_ack = 1'b1;
    step();
    sq.dcache_sq_ack = 1'b0;
  endtask

  initial begin
    sq.sq_enable = 0; sq.squash = 0; sq.rs_sq_out_valid = 0; sq.rs_sq_idx = 0;
    sq.rs_sq_addr = 0; sq.rs_sq_data = 0; sq.rs_sq_size = 0; sq.rob_commit_store = 0;
    sq.lb_request_valid = 0; sq.lb_request_addr = 0; sq.lb_request_age = 0;
    sq.lb_request_size = 0; sq.lb_request_preg = 0; sq.dcache_sq_ack = 0;

    // Reset state and fill to capacity
    do_reset();
    check("rst_empty",    32'(sq.sq_empty), 1);
    check("rst_full",     32'(sq.sq_full), 0);
    check("rst_secure",   32'(sq.secure_age), 0);
    check("rst_all_rsvd", 32'(sq.sq_addr_all_rsvd), 1);
    check("rst_fwd_v",    32'(sq.sq_fwd_valid), 0);
    check("rst_dc_v",     32'(sq.sq_dcache_valid), 0);
    check("rst_tail",     32'(sq.sq_tail), 0);
    alloc(8);
    check("fill_full",  32'(sq.sq_full), 1);
    check("fill_tail",  32'(sq.sq_tail), 0);
    check("fill_sec",   32'(sq.secure_age), 0);
    alloc(1);
    check("over_full",  32'(sq.sq_full), 1);
    check("over_tail",  32'(sq.sq_tail), 0);
    check("over_head",  32'(sq.sq_head), 0);

    // Resolve tracking and forwarding
    do_reset();
    alloc(3);
    check("a3_tail", 32'(sq.sq_tail), 3);
    resolve(3'd0, 32'h1000, 32'hAABBCCDD, 2'd2);
    resolve(3'd2, 32'h3000, 32'h11223344, 2'd2);
    check("r02_secure",   32'(sq.secure_age), 1);
    check("r02_all_rsvd", 32'(sq.sq_addr_all_rsvd), 0);
    resolve(3'd1, 32'h1000, 32'h000000EE, 2'd0);
    check("r1_secure",    32'(sq.secure_age), 3);
    check("r1_all_rsvd",  32'(sq.sq_addr_all_rsvd), 1);
    load(32'h1002, 3'd1, 2'd0, 5'd1, 1, 0, 32'h000000BB);
    load(32'h1000, 3'd2, 2'd2, 5'd2, 0, 1, 32'h0);
    load(32'h1000, 3'd0, 2'd2, 5'd3, 0, 0, 32'h0);
    load(32'h1002, 3'd2, 2'd1, 5'd4, 1, 0, 32'h0000AABB);
    load(32'h1000, 3'd2, 2'd0, 5'd5, 1, 0, 32'h000000EE);
    load(32'h3000, 3'd3, 2'd2, 5'd6, 1, 0, 32'h11223344);
    load(32'h4000, 3'd3, 2'd2, 5'd7, 0, 0, 32'h0);
    step(2);

    // Commit two of four, squash, then drain with delayed acks
    do_reset();
    alloc(4);
    resolve(3'd0, 32'h0100, 32'h01020304, 2'd2);
    resolve(3'd1, 32'h0106, 32'h0000BEEF, 2'd1);
    resolve(3'd2, 32'h0200, 32'h55555555, 2'd2);
    resolve(3'd3, 32'h0204, 32'h66666666, 2'd2);
    dc_q.push_back('{addr: 32'h0100, data: 32'h01020304, size: 2'd2});
    dc_q.push_back('{addr: 32'h0106, data: 32'h0000BEEF, size: 2'd1});
    sq.rob_commit_store = 1'b1;
    step(2);
    sq.rob_commit_store = 1'b0;
    sq.squash = 1'b1;
    sq.sq_enable = 1'b1;
    step();
    sq.squash = 1'b0;
    sq.sq_enable = 1'b0;
    check("sqh_tail",     32'(sq.sq_tail), 2);
    check("sqh_empty",    32'(sq.sq_empty), 0);
    check("sqh_secure",   32'(sq.secure_age), 2);
    check("sqh_all_rsvd", 32'(sq.sq_addr_all_rsvd), 1);
    ack_after(3);
    check("drain1_head",  32'(sq.sq_head), 1);
    ack_after(3);
    check("drain2_head",  32'(sq.sq_head), 2);
    check("drain2_empty", 32'(sq.sq_empty), 1);
    check("drain2_dcv",   32'(sq.sq_dcache_valid), 0);
    alloc(1);
    check("post_sqh_tail", 32'(sq.sq_tail), 3);

    // Wraparound: 12 alloc/resolve/commit/drain rounds
    do_reset();
    for (int i = 0; i < 12; i++) begin
      alloc(1);
      dc_q.push_back('{addr: 32'h5000 + 32'(4 * i), data: 32'h100 + 32'(i * 17), size: 2'd2});
      set_resolve(3'(i % 8), 32'h5000 + 32'(4 * i), 32'h100 + 32'(i * 17), 2'd2);
      sq.rob_commit_store = 1'b1;
      step();
      sq.rs_sq_out_valid = 1'b0;
      sq.rob_commit_store = 1'b0;
      ack_after(0);
    end
    check("wrap_head",  32'(sq.sq_head), 4);
    check("wrap_tail",  32'(sq.sq_tail), 4);
    check("wrap_empty", 32'(sq.sq_empty), 1);
    alloc(6);
    check("wrap6_tail", 32'(sq.sq_tail), 2);
    resolve(3'd4, 32'h6000, 32'h44444444, 2'd2);
    resolve(3'd5, 32'h7000, 32'h12345678, 2'd2);
    resolve(3'd6, 32'h6000, 32'h66666666, 2'd2);
    resolve(3'd7, 32'h7001, 32'h00000077, 2'd0);
    resolve(3'd0, 32'h6000, 32'hA0B0C0D0, 2'd2);
    check("wrap_secure",   32'(sq.secure_age), 1);
    check("wrap_all_rsvd", 32'(sq.sq_addr_all_rsvd), 0);
    // Lookup in the same cycle as the resolve sees the entry still unresolved
    set_resolve(3'd1, 32'h9000, 32'hCAFEF00D, 2'd2);
    set_load(32'h9000, 3'd2, 2'd2, 5'd8, 0, 0, 32'h0);
    step();
    sq.rs_sq_out_valid = 1'b0;
    sq.lb_request_valid = 1'b0;
    check("wrap_secure2", 32'(sq.secure_age), 2);
    load(32'h9000, 3'd2, 2'd2, 5'd9,  1, 0, 32'hCAFEF00D);
    load(32'h6000, 3'd1, 2'd2, 5'd10, 1, 0, 32'hA0B0C0D0);
    load(32'h6000, 3'd0, 2'd2, 5'd11, 1, 0, 32'h66666666);
    load(32'h7001, 3'd7, 2'd0, 5'd12, 1, 0, 32'h00000056);
    load(32'h7001, 3'd0, 2'd0, 5'd13, 1, 0, 32'h00000077);
    load(32'h7000, 3'd2, 2'd1, 5'd14, 0, 1, 32'h0);
    load(32'h6000, 3'd4, 2'd2, 5'd15, 0, 0, 32'h0);
    step(3);

    check("fwd_q_drained", 32'(fwd_q.size()), 0);
    check("dc_q_drained",  32'(dc_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
